// File: rtl/gauss_pkg.sv
// Shared helpers for the streaming binomial Gaussian filter: coefficients,
// datapath widths and the legal kernel-size check.
package gauss_pkg;

  // Binomial coefficient C(n, k); row n = KSIZE-1 gives the 1-D kernel taps.
  function automatic int binom(input int n, input int k);
    int c;
    c = 1;
    for (int j = 0; j < k; j++) begin
      c = c * (n - j) / (j + 1);
    end
    return c;
  endfunction

  // Taps of one binomial row sum to 2^(KSIZE-1), hence the extra bits.
  function automatic int colsum_w(input int pix_w, input int ksize);
    return pix_w + ksize - 1;
  endfunction

  function automatic int norm_shift(input int ksize);
    return 2 * (ksize - 1);
  endfunction

  function automatic int acc_w(input int pix_w, input int ksize);
`ifdef GAUSS_ROUND_EN
    return pix_w + norm_shift(ksize) + 1;
`else
    return pix_w + norm_shift(ksize);
`endif
  endfunction

  function automatic bit ksize_legal(input int ksize);
    return (ksize == 3) || (ksize == 5) || (ksize == 7);
  endfunction

endpackage

// File: rtl/gauss_line_buffer.sv
// One image row of delay: read the pixel stored one row earlier at addr,
// then overwrite it with the current pixel when we is high.
module gauss_line_buffer #(
  parameter int PIX_W  = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  pix,
  output logic [PIX_W-1:0]  pix_delayed
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign pix_delayed = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= pix;
    end
  end

endmodule

// File: rtl/gauss_stream_filter.sv
// Streaming separable KSIZE x KSIZE binomial Gaussian with valid/ready flow.
// Define GAUSS_ROUND_EN to round half up at normalisation instead of truncating.
module gauss_stream_filter
  import gauss_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int KSIZE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eof,
  output logic [PIX_W-1:0] out_pix
);

  localparam int CS_W  = colsum_w(PIX_W, KSIZE);
  localparam int ACC_W = acc_w(PIX_W, KSIZE);
  localparam int NS    = norm_shift(KSIZE);
  localparam int NB    = KSIZE - 1;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  if (!ksize_legal(KSIZE)) begin : g_bad_ksize
    $error("gauss_stream_filter: KSIZE must be 3, 5 or 7");
  end

  function automatic logic [PIX_W-1:0] normalise(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] t;
`ifdef GAUSS_ROUND_EN
    t = acc + (ACC_W'(1) << (NS - 1));
`else
    t = acc;
`endif
    return PIX_W'(t >> NS);
  endfunction

  logic adv, accept;
  logic [COL_W-1:0] col, col_eff;
  logic [ROW_W-1:0] row, row_eff;
  logic col_last, row_last, win, win_first, win_last;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv && !rst;

  // in_sof re-anchors the accepted pixel at (0,0), abandoning any partial frame.
  assign col_eff   = in_sof ? '0 : col;
  assign row_eff   = in_sof ? '0 : row;
  assign col_last  = (col_eff == COL_W'(IMG_W - 1));
  assign row_last  = (row_eff == ROW_W'(IMG_H - 1));
  assign win       = (row_eff >= ROW_W'(KSIZE - 1)) && (col_eff >= COL_W'(KSIZE - 1));
  assign win_first = (row_eff == ROW_W'(KSIZE - 1)) && (col_eff == COL_W'(KSIZE - 1));
  assign win_last  = row_last && col_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row_eff + ROW_W'(1);
      end else begin
        col <= col_eff + COL_W'(1);
        row <= row_eff;
      end
    end
  end

  logic [PIX_W-1:0] lb_in  [NB];
  logic [PIX_W-1:0] lb_out [NB];
  logic [CS_W-1:0]  vterm  [KSIZE];
  logic [CS_W-1:0]  vsum;

  for (genvar j = 0; j < NB; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign lb_in[j] = in_pix;
    end else begin : g_chain
      assign lb_in[j] = lb_out[j-1];
    end
    gauss_line_buffer #(
      .PIX_W (PIX_W),
      .DEPTH (IMG_W),
      .ADDR_W(COL_W)
    ) u_lb (
      .clk        (clk),
      .we         (accept),
      .addr       (col_eff),
      .pix        (lb_in[j]),
      .pix_delayed(lb_out[j])
    );
  end

  for (genvar i = 0; i < KSIZE; i++) begin : g_vtap
    localparam logic [CS_W-1:0] B = CS_W'(binom(KSIZE - 1, i));
    if (i == 0) begin : g_new
      assign vterm[i] = CS_W'(in_pix) * B;
    end else begin : g_old
      assign vterm[i] = CS_W'(lb_out[i-1]) * B;
    end
  end

  always_comb begin
    vsum = '0;
    for (int i = 0; i < KSIZE; i++) begin
      vsum = vsum + vterm[i];
    end
  end

  // ---- stage 1: vertical column sum of the accepted pixel ----
  logic [CS_W-1:0] colsum_p0;
  logic vld_p0, win_p0, sof_p0, eof_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      win_p0 <= 1'b0;
      sof_p0 <= 1'b0;
      eof_p0 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= accept;
      win_p0 <= accept && win;
      sof_p0 <= accept && win_first;
      eof_p0 <= accept && win_last;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      colsum_p0 <= vsum;
    end
  end

  // ---- stage 2: horizontal weighted sum over the last KSIZE column sums ----
  logic [CS_W-1:0]  hsr   [NB];
  logic [CS_W-1:0]  tap   [KSIZE];
  logic [ACC_W-1:0] hterm [KSIZE];
  logic [ACC_W-1:0] hsum, acc_p1;
  logic vld_p1, sof_p1, eof_p1;

  for (genvar i = 0; i < KSIZE; i++) begin : g_htap
    localparam logic [ACC_W-1:0] B = ACC_W'(binom(KSIZE - 1, i));
    if (i == 0) begin : g_new
      assign tap[i] = colsum_p0;
    end else begin : g_old
      assign tap[i] = hsr[i-1];
    end
    assign hterm[i] = ACC_W'(tap[i]) * B;
  end

  always_comb begin
    hsum = '0;
    for (int i = 0; i < KSIZE; i++) begin
      hsum = hsum + hterm[i];
    end
  end

  // Column sums shift on every accepted pixel, row wraps included; windows
  // that would straddle a wrap are never flagged, so stale taps stay unseen.
  always_ff @(posedge clk) begin
    if (adv && vld_p0) begin
      hsr[0] <= colsum_p0;
      for (int i = 1; i < NB; i++) begin
        hsr[i] <= hsr[i-1];
      end
    end
    if (adv && win_p0) begin
      acc_p1 <= hsum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      eof_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= win_p0;
      sof_p1 <= sof_p0;
      eof_p1 <= eof_p0;
    end
  end

  // ---- stage 3: normalise into the output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_pix   <= '0;
    end else if (adv) begin
      out_valid <= vld_p1;
      out_sof   <= vld_p1 && sof_p1;
      out_eof   <= vld_p1 && eof_p1;
      if (vld_p1) begin
        out_pix <= normalise(acc_p1);
      end
    end
  end

endmodule

// File: tb/tb_gauss_stream_filter.sv
// Directed bench for gauss_stream_filter: a KSIZE=5 and a KSIZE=3 instance
// (8x8 frames) share one stimulus driver selected by sel.
module tb_gauss_stream_filter;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_sof, out_ready, sel, stall_en;
  logic [7:0] in_pix;

  logic iv5, ir5, or5, ov5, os5, oe5;
  logic iv3, ir3, or3, ov3, os3, oe3;
  logic [7:0] op5, op3;
  logic in_ready_m, out_valid_m, out_sof_m, out_eof_m;
  logic [7:0] out_pix_m;

  assign iv5 = in_valid && !sel;
  assign iv3 = in_valid && sel;
  assign or5 = sel ? 1'b1 : out_ready;
  assign or3 = sel ? out_ready : 1'b1;
  assign in_ready_m  = sel ? ir3 : ir5;
  assign out_valid_m = sel ? ov3 : ov5;
  assign out_sof_m   = sel ? os3 : os5;
  assign out_eof_m   = sel ? oe3 : oe5;
  assign out_pix_m   = sel ? op3 : op5;

  gauss_stream_filter #(.PIX_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H), .KSIZE(5)) u_k5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .in_sof(in_sof), .in_pix(in_pix),
    .out_valid(ov5), .out_ready(or5), .out_sof(os5), .out_eof(oe5), .out_pix(op5)
  );

  gauss_stream_filter #(.PIX_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H), .KSIZE(3)) u_k3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_sof(in_sof), .in_pix(in_pix),
    .out_valid(ov3), .out_ready(or3), .out_sof(os3), .out_eof(oe3), .out_pix(op3)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall_viol = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_pix = 8'd0;
  logic [7:0] cap_pix [$];
  bit         cap_sof [$];
  bit         cap_eof [$];
  int         cap_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every handshake and flags any change while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!out_valid_m || out_pix_m != prev_pix)) stall_viol <= stall_viol + 1;
      if (out_valid_m && out_ready) begin
        cap_pix.push_back(out_pix_m);
        cap_sof.push_back(out_sof_m);
        cap_eof.push_back(out_eof_m);
        cap_cyc.push_back(cyc);
      end
      prev_stall <= out_valid_m && !out_ready;
      prev_pix   <= out_pix_m;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int cr;
    int cc;
    int exp_t;
    int exp_r;
  } imp_vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix_of(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'd100;
      1:       return (r == 3 && c == 3) ? 8'd255 : 8'd0;
      2:       return 8'(4 * r + 3 * c);
      3:       return 8'd200;
      default: return 8'd50;
    endcase
  endfunction

  // Ramp is linear, so every 5x5 binomial window returns its centre pixel exactly.
  function automatic int ramp_exp(input int i);
    return 4 * (i / 4 + 2) + 3 * (i % 4 + 2);
  endfunction

  task automatic next_ready();
    out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send_pixel(input logic [7:0] p, input bit sof, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    in_valid = 1'b1;
    in_pix = p;
    in_sof = sof;
    for (int g = 0; g < 200 && !got; g++) begin
      @(negedge clk);
      got = in_ready_m;
      acc = cyc;
      @(posedge clk);
      #1;
      next_ready();
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic send_frame(input int kind, input int npix, output int lat_acc);
    int k, a;
    k = sel ? 3 : 5;
    lat_acc = -1;
    for (int idx = 0; idx < npix; idx++) begin
      send_pixel(pix_of(kind, idx / IMG_W, idx % IMG_W), idx == 0, a);
      if (idx / IMG_W == k - 1 && idx % IMG_W == k - 1) lat_acc = a;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      next_ready();
    end
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_ramp(input string tag, input int base, input int first);
    for (int i = 0; i < 16; i++) begin
      if (base + first + i < cap_pix.size()) begin
        check({tag, "_pix"}, int'(cap_pix[base + first + i]), ramp_exp(i));
        check({tag, "_sof"}, int'(cap_sof[base + first + i]), int'(i == 0));
        check({tag, "_eof"}, int'(cap_eof[base + first + i]), int'(i == 15));
      end
    end
  endtask

  imp_vec_t tbl [14];
  int base, lat, idx, exp_v;

  initial begin
    tbl[0]  = '{3, 3, 63, 64};
    tbl[1]  = '{2, 3, 31, 32};
    tbl[2]  = '{4, 3, 31, 32};
    tbl[3]  = '{3, 2, 31, 32};
    tbl[4]  = '{3, 4, 31, 32};
    tbl[5]  = '{2, 2, 15, 16};
    tbl[6]  = '{2, 4, 15, 16};
    tbl[7]  = '{4, 2, 15, 16};
    tbl[8]  = '{4, 4, 15, 16};
    tbl[9]  = '{1, 1, 0, 0};
    tbl[10] = '{6, 6, 0, 0};
    tbl[11] = '{3, 5, 0, 0};
    tbl[12] = '{5, 3, 0, 0};
    tbl[13] = '{1, 6, 0, 0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_pix = 8'd0;
    out_ready = 1'b1;
    sel = 1'b0;
    stall_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", int'(ov5), 0);
    check("rst_out_sof", int'(os5), 0);
    check("rst_out_eof", int'(oe5), 0);
    check("rst_out_pix", int'(op5), 0);
    check("rst_in_ready", int'(ir5), 1);
    check("rst_in_ready_k3", int'(ir3), 1);

    // Constant frame, KSIZE=5: 16 windows of 100, plus first-output latency.
    base = cap_pix.size();
    send_frame(0, 64, lat);
    drain(20);
    check("const_count", cap_pix.size() - base, 16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < cap_pix.size()) begin
        check("const_pix", int'(cap_pix[base + i]), 100);
        check("const_sof", int'(cap_sof[base + i]), int'(i == 0));
        check("const_eof", int'(cap_eof[base + i]), int'(i == 15));
      end
    end
    if (base < cap_pix.size()) check("latency", cap_cyc[base] - lat, 3);

    // Single 255 impulse, KSIZE=3: table of window centres and expected values.
    sel = 1'b1;
    base = cap_pix.size();
    send_frame(1, 64, lat);
    drain(20);
    check("imp_count", cap_pix.size() - base, 36);
    for (int t = 0; t < 14; t++) begin
      idx = (tbl[t].cr - 1) * 6 + (tbl[t].cc - 1);
`ifdef GAUSS_ROUND_EN
      exp_v = tbl[t].exp_r;
`else
      exp_v = tbl[t].exp_t;
`endif
      if (base + idx < cap_pix.size()) check($sformatf("imp_r%0dc%0d", tbl[t].cr, tbl[t].cc), int'(cap_pix[base + idx]), exp_v);
    end
    if (base + 35 < cap_pix.size()) begin
      check("imp_sof_first", int'(cap_sof[base]), 1);
      check("imp_eof_last", int'(cap_eof[base + 35]), 1);
      check("imp_eof_first", int'(cap_eof[base]), 0);
    end
    sel = 1'b0;

    // Ramp without and then with random backpressure: same sequence, stable while stalled.
    base = cap_pix.size();
    send_frame(2, 64, lat);
    drain(20);
    check("ramp_count", cap_pix.size() - base, 16);
    check_ramp("ramp", base, 0);

    stall_en = 1'b1;
    base = cap_pix.size();
    send_frame(2, 64, lat);
    drain(80);
    stall_en = 1'b0;
    check("stall_count", cap_pix.size() - base, 16);
    check_ramp("stall", base, 0);
    check("stall_stable", stall_viol, 0);

    // Reset in mid-frame with a pixel offered during reset, then a fresh ramp frame.
    send_frame(3, 38, lat);
    in_valid = 1'b1;
    in_pix = 8'd7;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    base = cap_pix.size();
    send_frame(2, 64, lat);
    drain(20);
    check("rst_mid_count", cap_pix.size() - base, 16);
    check_ramp("rst_mid", base, 0);

    // in_sof at row 4: two windows of the abandoned frame drain, then the new frame.
    base = cap_pix.size();
    send_frame(4, 38, lat);
    send_frame(2, 64, lat);
    drain(20);
    check("sof_mid_count", cap_pix.size() - base, 18);
    if (base + 1 < cap_pix.size()) begin
      check("sof_mid_old0", int'(cap_pix[base]), 50);
      check("sof_mid_old1", int'(cap_pix[base + 1]), 50);
      check("sof_mid_old_sof", int'(cap_sof[base]), 1);
      check("sof_mid_old_eof", int'(cap_eof[base + 1]), 0);
    end
    check_ramp("sof_mid", base, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
